// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder step per clock, LSB first, through a single carry flop.
// Operands load on an accepted start; sum/cout update only when the last bit is produced.
module serial_full_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [WIDTH-1:0] b_reg, b_next;
   logic [WIDTH-1:0] res_reg, res_next;
   logic [WIDTH-1:0] sum_reg, sum_next;
   logic             carry_reg, carry_next;
   logic             cout_reg, cout_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic             bit_sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         res_reg   <= res_next;
         sum_reg   <= sum_next;
         carry_reg <= carry_next;
         cout_reg  <= cout_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      res_next   = res_reg;
      sum_next   = sum_reg;
      carry_next = carry_reg;
      cout_next  = cout_reg;
      cnt_next   = cnt_reg;
      bit_sum    = a_reg[0] ^ b_reg[0] ^ carry_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               a_next     = a;
               b_next     = b;
               carry_next = cin;
               cnt_next   = '0;
            end
         end
         RUN: begin
            a_next     = a_reg >> 1;
            b_next     = b_reg >> 1;
            carry_next = (a_reg[0] & b_reg[0]) | (a_reg[0] & carry_reg) | (b_reg[0] & carry_reg);
            // Result bits enter at the MSB so the first (LSB) bit lands at bit 0 after WIDTH steps.
            res_next             = res_reg >> 1;
            res_next[WIDTH-1]    = bit_sum;
            cnt_next             = cnt_reg + CW'(1);
            if (cnt_reg == CW'(WIDTH - 1)) begin
               state_next = DONE;
               sum_next   = res_next;
               cout_next  = carry_next;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state_reg != IDLE);
   assign done = (state_reg == DONE);
   assign sum  = sum_reg;
   assign cout = cout_reg;

endmodule
